// File: rtl/uart_vip_rx_deserializer_pkg.sv
// Shared types and helpers for the UART VIP receive and transmit paths.
// Holds the frame state encoding, the captured configuration and the character-length mapping.
package uart_vip_pkg;

   localparam int MIN_DIV   = 3;
   localparam int CFG_DIV_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP1  = 3'd4,
      ST_STOP2  = 3'd5
   } rx_state_e;

   typedef struct packed {
      logic [CFG_DIV_W-1:0] div;
      logic [1:0]           bits;
      logic                 parity_en;
      logic                 parity_odd;
      logic                 stop2;
   } uart_cfg_t;

   // 00..11 select 5..8 data bits.
   function automatic logic [3:0] data_bit_count(input logic [1:0] bits);
      return 4'd5 + {2'b00, bits};
   endfunction

endpackage

// File: rtl/uart_vip_rx_deserializer_bit_timer.sv
// Loadable bit-period down-counter. Fires a one-cycle strobe at zero and reloads the period.
// The load port sets the half-period phase at frame start; the serializer reuses it unchanged.
module uart_bit_timer #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_run,
   input  logic [W-1:0] i_period,
   output logic         o_strobe
);

   logic [W-1:0] r_cnt;

   assign o_strobe = i_run && (r_cnt == '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (o_strobe) begin
         r_cnt <= i_period;
      end else if (i_run) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

endmodule

// File: rtl/uart_vip_rx_deserializer.sv
// UART frame receiver: synchronizes the serial line, recovers one character per frame with
// parity/framing status and presents it on a valid/ready port with overflow reporting.
module uart_vip_rx_deserializer
   import uart_vip_pkg::*;
#(
   parameter int DIV_W  = 16,
   parameter int DATA_W = 8
) (
   input  logic              sys_clk_i,
   input  logic              rst_i,
   input  logic              uart_rx_i,
   input  logic              cfg_en_i,
   input  logic [DIV_W-1:0]  cfg_div_i,
   input  logic [1:0]        cfg_bits_i,
   input  logic              cfg_parity_en_i,
   input  logic              cfg_parity_odd_i,
   input  logic              cfg_stop2_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              parity_err_o,
   output logic              frame_err_o,
   output logic              overflow_o,
   output logic              busy_o,
   output logic [2:0]        dbg_state_o
);

   // Output handshake: a character is transferred in every cycle where valid_o and ready_i
   // are both high; valid_o is registered, and data_o/flags hold while valid_o && !ready_i.

   localparam int IDX_W = $clog2(DATA_W);

   rx_state_e          r_state;
   rx_state_e          w_state_nxt;
   uart_cfg_t          r_cfg;
   logic               r_sync1;
   logic               r_rx_s;
   logic               r_rx_prev;
   logic [IDX_W-1:0]   r_idx;
   logic [DATA_W-1:0]  r_shift;
   logic               r_par_err;
   logic               r_frm_err;
   logic               r_deliver;
   logic               r_valid;
   logic [DATA_W-1:0]  r_data;
   logic               r_pe_out;
   logic               r_fe_out;
   logic               r_ovf;

   logic               w_fall;
   logic               w_strobe;
   logic [DIV_W-1:0]   w_div_e_in;
   logic [DIV_W-1:0]   w_half;
   logic [3:0]         w_nbits;
   logic               w_start;
   logic               w_shift;
   logic               w_par_chk;
   logic               w_stop_chk;
   logic               w_done;

   assign w_fall     = r_rx_prev && !r_rx_s;
   assign w_div_e_in = (cfg_div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div_i;
   // (div_e + 1) >> 1 without widening: the first strobe lands mid start bit.
   assign w_half     = (w_div_e_in >> 1) + {{(DIV_W-1){1'b0}}, w_div_e_in[0]};
   assign w_nbits    = data_bit_count(r_cfg.bits);

   uart_bit_timer #(
      .W (DIV_W)
   ) u_timer (
      .i_clk      (sys_clk_i),
      .i_rst      (rst_i),
      .i_load     (w_start),
      .i_load_val (w_half),
      .i_run      (r_state != ST_IDLE),
      .i_period   (r_cfg.div[DIV_W-1:0]),
      .o_strobe   (w_strobe)
   );

   always_ff @(posedge sys_clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_shift     = 1'b0;
      w_par_chk   = 1'b0;
      w_stop_chk  = 1'b0;
      w_done      = 1'b0;
      if ((r_state != ST_IDLE) && !cfg_en_i) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cfg_en_i && w_fall) begin
                  w_start     = 1'b1;
                  w_state_nxt = ST_START;
               end
            end
            ST_START: begin
               if (w_strobe) begin
                  w_state_nxt = r_rx_s ? ST_IDLE : ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_strobe) begin
                  w_shift = 1'b1;
                  if (4'(r_idx) == (w_nbits - 4'd1)) begin
                     w_state_nxt = r_cfg.parity_en ? ST_PARITY : ST_STOP1;
                  end
               end
            end
            ST_PARITY: begin
               if (w_strobe) begin
                  w_par_chk   = 1'b1;
                  w_state_nxt = ST_STOP1;
               end
            end
            ST_STOP1: begin
               if (w_strobe) begin
                  w_stop_chk = 1'b1;
                  if (r_cfg.stop2) begin
                     w_state_nxt = ST_STOP2;
                  end else begin
                     w_state_nxt = ST_IDLE;
                     w_done      = 1'b1;
                  end
               end
            end
            ST_STOP2: begin
               if (w_strobe) begin
                  w_stop_chk  = 1'b1;
                  w_state_nxt = ST_IDLE;
                  w_done      = 1'b1;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk_i) begin
      if (rst_i) begin
         r_sync1   <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_prev <= 1'b1;
         r_cfg     <= '0;
         r_idx     <= '0;
         r_shift   <= '0;
         r_par_err <= 1'b0;
         r_frm_err <= 1'b0;
         r_deliver <= 1'b0;
         r_valid   <= 1'b0;
         r_data    <= '0;
         r_pe_out  <= 1'b0;
         r_fe_out  <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_sync1   <= uart_rx_i;
         r_rx_s    <= r_sync1;
         r_rx_prev <= r_rx_s;
         if (w_start) begin
            r_cfg.div        <= CFG_DIV_W'(w_div_e_in);
            r_cfg.bits       <= cfg_bits_i;
            r_cfg.parity_en  <= cfg_parity_en_i;
            r_cfg.parity_odd <= cfg_parity_odd_i;
            r_cfg.stop2      <= cfg_stop2_i;
            r_idx            <= '0;
            r_shift          <= '0;
            r_par_err        <= 1'b0;
            r_frm_err        <= 1'b0;
         end
         if (w_shift) begin
            r_shift[r_idx] <= r_rx_s;
            r_idx          <= r_idx + IDX_W'(1);
         end
         // Unused MSBs of r_shift are zero, so reducing the whole vector is safe.
         if (w_par_chk) begin
            r_par_err <= (^r_shift) ^ r_rx_s ^ r_cfg.parity_odd;
         end
         if (w_stop_chk && !r_rx_s) begin
            r_frm_err <= 1'b1;
         end
         r_deliver <= w_done;
         r_ovf     <= 1'b0;
         if (r_deliver) begin
            if (!r_valid || ready_i) begin
               r_valid  <= 1'b1;
               r_data   <= r_shift;
               r_pe_out <= r_par_err;
               r_fe_out <= r_frm_err;
            end else begin
               r_ovf <= 1'b1;
            end
         end else if (ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign data_o       = r_data;
   assign valid_o      = r_valid;
   assign parity_err_o = r_pe_out;
   assign frame_err_o  = r_fe_out;
   assign overflow_o   = r_ovf;
   assign busy_o       = (r_state != ST_IDLE);
   assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_uart_vip_rx_deserializer.sv
// Bench for uart_vip_rx_deserializer: drives serial frames and checks delivered characters
// against a frame-level model of data, parity and stop-bit rules.
module tb_uart_vip_rx_deserializer;

   localparam int DIV_W  = 16;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              rx;
   logic              en;
   logic [DIV_W-1:0]  div;
   logic [1:0]        bits;
   logic              par_en;
   logic              par_odd;
   logic              stop2;
   logic [DATA_W-1:0] data_o;
   logic              valid_o;
   logic              ready;
   logic              parity_err_o;
   logic              frame_err_o;
   logic              overflow_o;
   logic              busy_o;
   logic [2:0]        dbg_state;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          n_ovf = 0;
   int          n_rise = 0;
   int          last_rise_cyc = 0;
   logic        prev_valid = 1'b0;
   logic        rand_ready = 1'b0;
   logic [9:0]  exp_q[$];

   uart_vip_rx_deserializer #(
      .DIV_W  (DIV_W),
      .DATA_W (DATA_W)
   ) dut (
      .sys_clk_i        (clk),
      .rst_i            (rst),
      .uart_rx_i        (rx),
      .cfg_en_i         (en),
      .cfg_div_i        (div),
      .cfg_bits_i       (bits),
      .cfg_parity_en_i  (par_en),
      .cfg_parity_odd_i (par_odd),
      .cfg_stop2_i      (stop2),
      .data_o           (data_o),
      .valid_o          (valid_o),
      .ready_i          (ready),
      .parity_err_o     (parity_err_o),
      .frame_err_o      (frame_err_o),
      .overflow_o       (overflow_o),
      .busy_o           (busy_o),
      .dbg_state_o      (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1 ready = ($urandom_range(0, 3) != 0);
      end
   end

   // scoreboard monitor
   always @(negedge clk) begin
      logic [9:0] exp;
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (overflow_o) n_ovf++;
         if (valid_o && !prev_valid) begin
            n_rise++;
            last_rise_cyc = cyc;
         end
         prev_valid = valid_o;
         if (valid_o && ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_char: got data=%h pe=%b fe=%b, required no character",
                        data_o, parity_err_o, frame_err_o);
            end else begin
               exp = exp_q.pop_front();
               if ({frame_err_o, parity_err_o, data_o} !== exp) begin
                  n_err++;
                  $display("FAIL char: got fe=%b pe=%b data=%h, required fe=%b pe=%b data=%h",
                           frame_err_o, parity_err_o, data_o, exp[9], exp[8], exp[7:0]);
               end
            end
         end
      end
   end

   // frame-level reference model: {frame_err, parity_err, data}
   function automatic logic [9:0] model(input logic [7:0] d, input int nbits, input logic pe,
                                        input logic po, input logic pbit, input logic s1,
                                        input logic s2v, input logic two);
      logic [7:0] m;
      int         ones;
      logic       perr;
      logic       ferr;
      m    = '0;
      ones = 0;
      for (int i = 0; i < nbits; i++) begin
         m[i] = d[i];
         if (d[i]) ones++;
      end
      if (pbit) ones++;
      // even parity wants an even count of ones over data+parity, odd wants odd
      perr = pe ? ((ones % 2) != (po ? 1 : 0)) : 1'b0;
      ferr = !s1 || (two && !s2v);
      return {ferr, perr, m};
   endfunction

   // driver tasks
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_bit(input logic b, input int p);
      rx = b;
      tick(p);
   endtask

   task automatic set_cfg(input int d, input int nbits, input logic pe, input logic po,
                          input logic two);
      div     = DIV_W'(d);
      bits    = 2'(nbits - 5);
      par_en  = pe;
      par_odd = po;
      stop2   = two;
   endtask

   task automatic send_frame(input logic [7:0] d, input int nbits, input logic pe,
                             input logic pbit, input logic s1, input logic s2v,
                             input logic two, input int p, input logic scramble,
                             output int t0);
      t0 = cyc;
      rx = 1'b0;
      if (scramble) begin
         tick(4);
         div     = DIV_W'($urandom_range(0, 20));
         bits    = 2'($urandom_range(0, 3));
         par_en  = 1'($urandom_range(0, 1));
         par_odd = 1'($urandom_range(0, 1));
         stop2   = 1'($urandom_range(0, 1));
         tick(p - 4);
      end else begin
         tick(p);
      end
      for (int i = 0; i < nbits; i++) drive_bit(d[i], p);
      if (pe) drive_bit(pbit, p);
      drive_bit(s1, p);
      if (two) drive_bit(s2v, p);
      rx = 1'b1;
   endtask

   task automatic xfer(input logic [7:0] d, input int nbits, input logic pe, input logic po,
                       input logic pbit, input logic s1, input logic s2v, input logic two,
                       input int dv, input logic scramble, output int t0);
      int p;
      p = ((dv < 3) ? 3 : dv) + 1;
      set_cfg(dv, nbits, pe, po, two);
      exp_q.push_back(model(d, nbits, pe, po, pbit, s1, s2v, two));
      send_frame(d, nbits, pe, pbit, s1, s2v, two, p, scramble, t0);
   endtask

   task automatic drain(input string name, input int budget);
      int b;
      b = 0;
      while ((exp_q.size() != 0) && (b < budget)) begin
         tick(1);
         b++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s_drain: got %0d characters outstanding after %0d cycles, required 0",
                  name, exp_q.size(), budget);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      n_cmp++;
      if ({valid_o, data_o, parity_err_o, frame_err_o, overflow_o, busy_o} !== '0) begin
         n_err++;
         $display("FAIL %s: got valid=%b data=%h pe=%b fe=%b ovf=%b busy=%b, required all 0",
                  name, valid_o, data_o, parity_err_o, frame_err_o, overflow_o, busy_o);
      end
   endtask

   task automatic check_no_rise(input string name, input int rise0);
      n_cmp++;
      if (n_rise !== rise0) begin
         n_err++;
         $display("FAIL %s: got %0d valid rises, required 0", name, n_rise - rise0);
      end
   endtask

   // tests
   task automatic test_reset();
      int   t0;
      int   rise0;
      logic [7:0] d;
      tick(3);
      check_idle_outputs("reset_initial");
      rst = 1'b0;
      tick(5);
      set_cfg(15, 8, 1'b0, 1'b0, 1'b0);
      d = 8'h5A;
      drive_bit(1'b0, 16);
      for (int i = 0; i < 3; i++) drive_bit(d[i], 16);
      rise0 = n_rise;
      rst = 1'b1;
      tick(2);
      check_idle_outputs("reset_midframe");
      rx = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(200);
      check_no_rise("reset_no_output", rise0);
      xfer(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 15, 1'b0, t0);
      drain("reset_clean", 100);
   endtask

   task automatic test_basic();
      int t0;
      int h;
      int p;
      int exp_lat;
      xfer(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 15, 1'b0, t0);
      drain("basic", 100);
      p = 16;
      h = p / 2;
      // 2 sync flops + detect, half bit to mid-start, 9 bits to mid-stop, deliver, register
      exp_lat = 3 + (h + 1) + 9 * p + 1;
      n_cmp++;
      if ((last_rise_cyc - t0) !== exp_lat) begin
         n_err++;
         $display("FAIL basic_latency: got %0d cycles, required %0d", last_rise_cyc - t0, exp_lat);
      end
   endtask

   task automatic test_parity();
      int t0;
      xfer(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 15, 1'b0, t0);
      drain("parity_even", 100);
      tick(20);
      xfer(8'h3C, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 15, 1'b0, t0);
      drain("parity_odd", 100);
      tick(20);
   endtask

   task automatic test_frame_err();
      int t0;
      xfer(8'h1F, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7, 1'b0, t0);
      rx = 1'b1;
      drain("frame_err", 100);
      tick(30);
   endtask

   task automatic test_glitch();
      int rise0;
      rise0 = n_rise;
      set_cfg(15, 8, 1'b0, 1'b0, 1'b0);
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      tick(1);
      n_cmp++;
      if (busy_o !== 1'b1) begin
         n_err++;
         $display("FAIL glitch_busy: got busy=%b, required 1", busy_o);
      end
      tick(30);
      n_cmp++;
      if (busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL glitch_idle: got busy=%b, required 0", busy_o);
      end
      check_no_rise("glitch_no_output", rise0);
   endtask

   task automatic test_disable();
      int rise0;
      int t0;
      rise0 = n_rise;
      set_cfg(15, 8, 1'b0, 1'b0, 1'b0);
      fork
         send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16, 1'b0, t0);
         begin
            tick(60);
            en = 1'b0;
            tick(2);
            n_cmp++;
            if (busy_o !== 1'b0) begin
               n_err++;
               $display("FAIL disable_abort: got busy=%b, required 0", busy_o);
            end
         end
      join
      tick(20);
      en = 1'b1;
      tick(30);
      check_no_rise("disable_no_output", rise0);
   endtask

   task automatic test_overflow();
      int t0;
      int ovf0;
      ready = 1'b0;
      ovf0 = n_ovf;
      set_cfg(15, 8, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(model(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
      send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16, 1'b0, t0);
      send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16, 1'b0, t0);
      tick(40);
      n_cmp++;
      if ({valid_o, data_o} !== {1'b1, 8'h11}) begin
         n_err++;
         $display("FAIL overflow_hold: got valid=%b data=%h, required valid=1 data=11",
                  valid_o, data_o);
      end
      n_cmp++;
      if ((n_ovf - ovf0) !== 1) begin
         n_err++;
         $display("FAIL overflow_pulse: got %0d pulses, required 1", n_ovf - ovf0);
      end
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      tick(5);
      n_cmp++;
      if (valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL overflow_drain: got valid=%b, required 0", valid_o);
      end
      drain("overflow", 1);
      ready = 1'b1;
   endtask

   task automatic test_random();
      int         t0;
      int         nbits;
      int         dv;
      int         p;
      logic       pe;
      logic       po;
      logic       two;
      logic       pbit;
      logic       s1;
      logic       s2v;
      logic [7:0] d;
      logic [7:0] m;
      rand_ready = 1'b1;
      for (int f = 0; f < 30; f++) begin
         nbits = $urandom_range(5, 8);
         dv    = $urandom_range(0, 12);
         pe    = 1'($urandom_range(0, 1));
         po    = 1'($urandom_range(0, 1));
         two   = 1'($urandom_range(0, 1));
         d     = 8'($urandom_range(0, 255));
         m     = '0;
         for (int i = 0; i < nbits; i++) m[i] = d[i];
         pbit  = (^m) ^ po ^ ($urandom_range(0, 3) == 0);
         s1    = ($urandom_range(0, 4) != 0);
         s2v   = ($urandom_range(0, 4) != 0);
         xfer(d, nbits, pe, po, pbit, s1, s2v, two, dv, 1'($urandom_range(0, 1)), t0);
         p = ((dv < 3) ? 3 : dv) + 1;
         tick(2 * p);
      end
      drain("random", 200);
      rand_ready = 1'b0;
      tick(2);
      ready = 1'b1;
   endtask

   initial begin
      rst     = 1'b1;
      rx      = 1'b1;
      en      = 1'b1;
      div     = DIV_W'(15);
      bits    = 2'b11;
      par_en  = 1'b0;
      par_odd = 1'b0;
      stop2   = 1'b0;
      ready   = 1'b1;
      test_reset();
      test_basic();
      test_parity();
      test_frame_err();
      test_glitch();
      test_disable();
      test_overflow();
      test_random();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL final_queue: got %0d outstanding, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_vip_rx_deserializer.md
Name: uart_vip_rx_deserializer

Overview:
- Serial-to-parallel UART frame receiver for the UART verification environment.
- Sits directly downstream of the DUT serial output (uart_tx_o). It samples that line and recovers each character with parity and framing status.
- Presents each character on a valid/ready byte port to the monitor/scoreboard side.
- Synthesizable; runs on the system clock with a programmable bit-period divider.

Parameters:
- DIV_W, 16, width of the clocks-per-bit divider configuration.
- DATA_W, 8, maximum character width; the output bus width.

Ports:
- sys_clk_i  in  1  system clock; all logic is on its rising edge.
- rst_i  in  1  synchronous reset, active-high.
- uart_rx_i  in  1  serial line, connected to DUT uart_tx_o; idles high; asynchronous to sys_clk_i.
- cfg_en_i  in  1  receiver enable.
- cfg_div_i  in  DIV_W  bit period minus 1, in sys_clk_i cycles.
- cfg_bits_i  in  2  character length: 00=5, 01=6, 10=7, 11=8 bits.
- cfg_parity_en_i  in  1  a parity bit follows the data bits.
- cfg_parity_odd_i  in  1  1=odd parity, 0=even parity.
- cfg_stop2_i  in  1  1=two stop bits, 0=one stop bit.
- data_o  out  DATA_W  received character, LSB-aligned, unused MSBs zero.
- valid_o  out  1  data_o and its error flags are valid.
- ready_i  in  1  consumer accepts data_o.
- parity_err_o  out  1  parity mismatch for the character on data_o; qualified by valid_o.
- frame_err_o  out  1  a stop bit was sampled low for the character on data_o; qualified by valid_o.
- overflow_o  out  1  one-cycle pulse: a completed character was dropped.
- busy_o  out  1  a frame is in progress (state is not IDLE).

Behaviour:
- Reset:
  - valid_o, data_o, parity_err_o, frame_err_o, overflow_o and busy_o are all 0.
  - State is IDLE; both synchronizer flops are 1.
  - A reset asserted mid-frame discards the frame with no output.
- Synchronizer: two-flop synchronizer on uart_rx_i. Everything below uses the synchronized value rx_s.
- Bit timer:
  - Effective divider div_e = max(cfg_div_i, 3), so one bit period is div_e+1 cycles.
  - Down-counter; a sample strobe fires when it reaches 0, then the counter reloads div_e.
- Configuration capture: cfg_div_i, cfg_bits_i, cfg_parity_en_i, cfg_parity_odd_i and cfg_stop2_i are captured at start detection. Changes mid-frame have no effect on that frame.
- State machine:
  - IDLE: wait for cfg_en_i=1 and a falling edge on rx_s (previous 1, current 0). Then load the counter with (div_e+1)>>1 and go to START.
  - START: at the strobe, if rx_s=1 it is a false start: go to IDLE, no output. Otherwise go to DATA with bit index 0.
  - DATA: at each strobe, shift rx_s in LSB first. After the configured number of bits (5 to 8), go to PARITY if parity is enabled, else to STOP1.
  - PARITY: at the strobe, compute XOR of the data bits XOR rx_s XOR odd_flag. A result of 1 sets the internal parity error. Go to STOP1.
  - STOP1: at the strobe, rx_s=0 sets the internal frame error. Go to STOP2 if two stop bits are configured, else go to IDLE and deliver.
  - STOP2: same check as STOP1; then go to IDLE and deliver.
- Delivery (the cycle after the last stop-bit strobe):
  - If valid_o=0, or valid_o=1 and ready_i=1 in the same cycle: load data_o and both error flags, and set valid_o=1.
  - Otherwise (valid_o=1 and ready_i=0): pulse overflow_o for one cycle, drop the new character, and leave data_o and its flags unchanged.
- Handshake:
  - valid_o stays high until the cycle in which ready_i=1.
  - data_o and the flags are stable while valid_o=1 and ready_i=0.
  - valid_o never depends combinationally on ready_i.
- Back-to-back frames: IDLE is re-entered at the middle of the stop bit, so a start bit that immediately follows is detected.
- Disable: cfg_en_i=0 in any non-IDLE state aborts to IDLE on the next cycle with no delivery. A pending valid_o character is kept.
- Latency: valid_o rises 2 cycles after the final stop-bit strobe (1 cycle to deliver plus the registered output).

Decomposition:
- uart_vip_pkg holds:
  - the rx_state_e enum (IDLE, START, DATA, PARITY, STOP1, STOP2);
  - the uart_cfg_t struct (div, bits, parity_en, parity_odd, stop2);
  - the constant MIN_DIV=3;
  - a function mapping cfg_bits to a data-bit count.
- One sub-module, uart_bit_timer: the loadable down-counter with a strobe output and half-period load. It is reused later by the matching serializer.

Test Plan:
- Reset value check: assert rst_i during an 8N1 frame of 0x5A at cfg_div_i=15 -> all outputs 0 during reset, no valid_o for the interrupted frame; a following clean 0x5A is received correctly.
- cfg_div_i=15, 8N1, send 0xA5 -> one valid_o, data_o=0x A5 written as 0xA5, parity_err_o=0, frame_err_o=0; valid_o rises 2 cycles after the mid-stop strobe.
- cfg_div_i=15, 8E1, send 0x3C with parity bit 1 (wrong) -> data_o=0x3C, parity_err_o=1. Repeat with odd parity and parity bit 1 -> parity_err_o=0.
- cfg_div_i=7, 5-bit data, two stop bits, send 0x1F with the second stop bit low -> data_o=0x1F, frame_err_o=1.
- rx low glitch of 3 cycles at cfg_div_i=15 -> false start, busy_o returns to 0, no valid_o.
- ready_i held 0, two back-to-back frames 0x11 then 0x22 -> data_o stays 0x11, overflow_o pulses once; ready_i=1 then drains 0x11 only.
